ex_alu_pipe: RTL and testbench
==============================

// Module: ex_alu_pipe
// PURPOSE
//   Parametrised execute-stage ALU with valid/ready handshake, registered result, optional
//   ADD/SUB saturation and an iterative shift-add multiplier. Sits between decode and
//   memory/writeback. Owns the ov/neg/zero condition flags read by branch logic.
// PARAMETERS
//   DATA_W  32  operand/result width (>=8)
//   IMM_W   17  immediate width; sign-extended to DATA_W when use_imm=1
//   MUL_EN  1   1: opcode MUL implemented; 0: MUL treated as undefined opcode
// PORTS
//   clk              in   1        clock, all state on rising edge
//   rst_n            in   1        asynchronous active-low reset
//   in_valid         in   1        operation presented
//   in_ready         out  1        block can accept this cycle
//   alu_opcode       in   4        0 ADD,1 SUB,2 AND,3 OR,4 NOR,5 SLL,6 SRL,7 SRA,8 MUL,9-15 undefined
//   s_data           in   DATA_W   src0
//   t_data           in   DATA_W   src1 when use_imm=0
//   imm              in   IMM_W    src1 (sign-extended) when use_imm=1
//   use_imm          in   1        select imm as src1
//   sat_en           in   1        saturate ADD/SUB on signed overflow
//   update_flag_ov   in   1        write flag_ov with this op's result
//   update_flag_neg  in   1        write flag_neg with this op's result
//   update_flag_zero in   1        write flag_zero with this op's result
//   out_valid        out  1        ALU_result valid
//   out_ready        in   1        downstream consumes result
//   ALU_result       out  DATA_W   registered result
//   flag_ov          out  1        overflow flag
//   flag_neg         out  1        true-sign flag
//   flag_zero        out  1        zero flag
//   busy             out  1        multiply in progress
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=0 during reset, then 1; out_valid, ALU_result, all flags, busy = 0.
//   Accept: in_valid && in_ready at a rising edge; all inputs, including the update_flag_*
//     bits, are captured at that edge.
//   in_ready = (state==IDLE) && (!out_valid || out_ready).
//   FSM: IDLE -> MUL on accepting MUL (MUL_EN=1); MUL -> IDLE after DATA_W steps.
//   Latency: non-MUL ops: ALU_result/out_valid valid after the accept edge (1 cycle).
//     MUL: one shift-add step per edge; result and out_valid after edge accept+DATA_W;
//     busy=1 over those DATA_W cycles.
//   out_valid && !out_ready: ALU_result and out_valid held unchanged; no new accept.
//   out_valid clears on the edge where out_ready=1, unless a new result is written on that edge.
//   Back-to-back non-MUL ops at 1/cycle while out_ready=1.
//   Arithmetic: mod-2^DATA_W.
//     ADD/SUB ov = signed overflow; neg = msb(raw) ^ ov.
//     sat_en && ov: result = max positive (sum>0) or min negative (sum<0).
//   Logic/shift: shift amount = src1[clog2(DATA_W)-1:0]; SRA sign-fills.
//     ov = 0; neg = result msb.
//   MUL: unsigned DATA_W x DATA_W; 2*DATA_W accumulator; result = low half.
//     ov = (high half != 0); neg = result msb; sat_en ignored.
//   Undefined opcodes (and MUL with MUL_EN=0): result 0, ov=0, neg=0, latency 1.
//   zero = (final result == 0), evaluated after saturation.
//   Flags: written only on the edge that writes ALU_result, each only if its captured update
//     bit=1; otherwise held.
//   Reset mid-multiply: operation discarded; all outputs return to reset values.
// TESTING
//   Reset in IDLE -> outputs 0; in_ready=1 after release.
//   Back-to-back, DATA_W=32, out_ready=1, all update bits=1:
//     ADD 7FFFFFFF+1 (sat_en=0) -> 80000000; ov=1, neg=0, zero=0.
//     Then SUB 5-5 -> 0; zero=1, ov=0.
//   ADD 7FFFFFFF+1, sat_en=1 -> 7FFFFFFF, ov=1.
//   SUB 80000000-1, sat_en=1 -> 80000000, ov=1.
//   SRA s=F0000000, imm=4 -> FF000000.
//   MUL 0x10000 x 0x10000 -> out_valid exactly 32 cycles after accept; result 0, ov=1,
//     zero=1, busy=1 throughout.
//   Hold out_ready=0 for 5 cycles after a result -> ALU_result stable, in_ready=0.
//   Then out_ready=1 -> next op accepted.
//   Assert rst_n=0 mid-MUL -> all outputs 0; next op executes normally.

Source files
------------

// File: rtl/ex_alu_pipe.sv
// Execute-stage ALU with a valid/ready handshake on both sides, a registered
// result and flags, optional ADD/SUB saturation and an iterative shift-add
// multiplier that takes DATA_W cycles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream must hold its inputs stable while in_valid=1 and
// in_ready=0. Downstream sees ALU_result held stable while out_valid=1 and
// out_ready=0. in_ready never depends on in_valid.
module ex_alu_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 17,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DATA_W-1:0] t_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic              use_imm,
    input  logic              sat_en,
    input  logic              update_flag_ov,
    input  logic              update_flag_neg,
    input  logic              update_flag_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALU_result,
    output logic              flag_ov,
    output logic              flag_neg,
    output logic              flag_zero,
    output logic              busy,
    output logic [0:0]        dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam int SHW = $clog2(DATA_W);
    localparam int CW  = $clog2(DATA_W) + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   result_q;
    logic                flag_ov_q, flag_neg_q, flag_zero_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2:0]          upd_q;

    logic [DATA_W-1:0]   src1;
    logic [SHW-1:0]      sh;
    logic [DATA_W-1:0]   sum, diff;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_ov, alu_neg;
    logic                is_mul;
    logic                accept;
    logic [2*DATA_W-1:0] acc_nx;
    logic                mul_last;
    logic                wr_alu, wr_en;
    logic [DATA_W-1:0]   wr_res;
    logic                wr_ov, wr_neg;
    logic [2:0]          wr_upd;

    assign in_ready   = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign ALU_result = result_q;
    assign flag_ov    = flag_ov_q;
    assign flag_neg   = flag_neg_q;
    assign flag_zero  = flag_zero_q;
    assign busy       = (state_q == ST_MUL);
    assign dbg_state  = state_q;

    // Single-cycle ALU: operand select, arithmetic with saturation, logic and shifts.
    always_comb begin
        src1    = use_imm ? DATA_W'($signed(imm)) : t_data;
        sh      = src1[SHW-1:0];
        sum     = s_data + src1;
        diff    = s_data - src1;
        alu_res = '0;
        alu_ov  = 1'b0;
        alu_neg = 1'b0;
        is_mul  = (MUL_EN != 0) && (alu_opcode == OP_MUL);
        case (alu_opcode)
            OP_ADD: begin
                alu_ov  = (s_data[DATA_W-1] == src1[DATA_W-1]) &&
                          (sum[DATA_W-1] != s_data[DATA_W-1]);
                alu_neg = sum[DATA_W-1] ^ alu_ov;
                alu_res = (sat_en && alu_ov) ? (alu_neg ? MIN_NEG : MAX_POS) : sum;
            end
            OP_SUB: begin
                alu_ov  = (s_data[DATA_W-1] != src1[DATA_W-1]) &&
                          (diff[DATA_W-1] != s_data[DATA_W-1]);
                alu_neg = diff[DATA_W-1] ^ alu_ov;
                alu_res = (sat_en && alu_ov) ? (alu_neg ? MIN_NEG : MAX_POS) : diff;
            end
            OP_AND: alu_res = s_data & src1;
            OP_OR:  alu_res = s_data | src1;
            OP_NOR: alu_res = ~(s_data | src1);
            OP_SLL: alu_res = s_data << sh;
            OP_SRL: alu_res = s_data >> sh;
            OP_SRA: alu_res = $signed(s_data) >>> sh;
            default: alu_res = '0;
        endcase
        // Logic and shift ops report the plain result sign.
        if (alu_opcode inside {OP_AND, OP_OR, OP_NOR, OP_SLL, OP_SRL, OP_SRA}) begin
            alu_neg = alu_res[DATA_W-1];
        end
    end

    // Multiplier step and selection of what gets written to the output registers.
    always_comb begin
        acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_last = (state_q == ST_MUL) && (cnt_q == CW'(DATA_W - 1));
        wr_alu   = accept && !is_mul;
        wr_en    = wr_alu || mul_last;
        wr_res   = wr_alu ? alu_res : acc_nx[DATA_W-1:0];
        wr_ov    = wr_alu ? alu_ov  : (acc_nx[2*DATA_W-1:DATA_W] != '0);
        wr_neg   = wr_alu ? alu_neg : acc_nx[DATA_W-1];
        wr_upd   = wr_alu ? {update_flag_ov, update_flag_neg, update_flag_zero} : upd_q;
    end

    // Next state for the FSM, step counter and output-valid bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (wr_en) begin
            out_valid_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_d = ST_MUL;
                    cnt_d   = '0;
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 1'b1;
                if (mul_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Shift-add datapath: load operands on accept, one partial product per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            upd_q    <= '0;
        end else if (accept && is_mul) begin
            mcand_q  <= {{DATA_W{1'b0}}, s_data};
            mplier_q <= src1;
            acc_q    <= '0;
            upd_q    <= {update_flag_ov, update_flag_neg, update_flag_zero};
        end else if (state_q == ST_MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_nx;
        end
    end

    // Result and condition flags; each flag only moves when its captured update bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            flag_ov_q   <= 1'b0;
            flag_neg_q  <= 1'b0;
            flag_zero_q <= 1'b0;
        end else if (wr_en) begin
            result_q <= wr_res;
            if (wr_upd[2]) flag_ov_q   <= wr_ov;
            if (wr_upd[1]) flag_neg_q  <= wr_neg;
            if (wr_upd[0]) flag_zero_q <= (wr_res == '0);
        end
    end

endmodule

// File: tb/tb_ex_alu_pipe.sv
// Directed bench for ex_alu_pipe: stimulus pushes hand-computed results into a
// queue; an independent monitor pops and compares on each output transfer.
module tb_ex_alu_pipe;

  localparam int W = 32;

  logic          clk, rst_n;
  logic          in_valid, in_ready;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  s_data, t_data;
  logic [16:0]   imm;
  logic          use_imm, sat_en;
  logic          update_flag_ov, update_flag_neg, update_flag_zero;
  logic          out_valid, out_ready;
  logic [W-1:0]  ALU_result;
  logic          flag_ov, flag_neg, flag_zero, busy;
  logic [0:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int out_idx = 0;

  // {result, ov, neg, zero}
  logic [W+2:0] exp_q[$];

  ex_alu_pipe #(.DATA_W(W), .IMM_W(17), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_opcode(alu_opcode), .s_data(s_data), .t_data(t_data), .imm(imm),
    .use_imm(use_imm), .sat_en(sat_en),
    .update_flag_ov(update_flag_ov), .update_flag_neg(update_flag_neg),
    .update_flag_zero(update_flag_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_result(ALU_result),
    .flag_ov(flag_ov), .flag_neg(flag_neg), .flag_zero(flag_zero),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // driver: present one op, wait (bounded) for acceptance
  task automatic issue(input logic [3:0] op, input logic [W-1:0] s, input logic [W-1:0] t,
                       input logic [16:0] im, input logic ui, input logic sat,
                       input logic [2:0] upd, input logic [W-1:0] er,
                       input logic eo, input logic en, input logic ez, input bit push);
    int n;
    alu_opcode       = op;
    s_data           = s;
    t_data           = t;
    imm              = im;
    use_imm          = ui;
    sat_en           = sat;
    update_flag_ov   = upd[2];
    update_flag_neg  = upd[1];
    update_flag_zero = upd[0];
    in_valid         = 1'b1;
    if (push) exp_q.push_back({er, eo, en, ez});
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: op %0d never accepted", op);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // scoreboard monitor: compare on every output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: result %h", ALU_result);
      end else begin
        logic [W+2:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({ALU_result, flag_ov, flag_neg, flag_zero} !== e) begin
          errors++;
          $display("FAIL result_%0d: got res=%h ov=%b neg=%b zero=%b expected res=%h ov=%b neg=%b zero=%b",
                   out_idx, ALU_result, flag_ov, flag_neg, flag_zero,
                   e[W+2:3], e[2], e[1], e[0]);
        end
        out_idx++;
      end
    end
  end

  initial begin
    bit bad;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_opcode = '0; s_data = '0; t_data = '0; imm = '0;
    use_imm = 1'b0; sat_en = 1'b0;
    update_flag_ov = 1'b0; update_flag_neg = 1'b0; update_flag_zero = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_outputs", {27'd0, ALU_result, out_valid, flag_ov, flag_neg, flag_zero, busy}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    sync();

    // back-to-back ops, all update bits set
    issue(4'd0, 32'h7FFFFFFF, 32'h1, '0, 0, 0, 3'b111, 32'h80000000, 1, 0, 0, 1);
    issue(4'd1, 32'd5, 32'd5, '0, 0, 0, 3'b111, 32'h0, 0, 0, 1, 1);
    // saturation
    issue(4'd0, 32'h7FFFFFFF, 32'h1, '0, 0, 1, 3'b111, 32'h7FFFFFFF, 1, 0, 0, 1);
    issue(4'd1, 32'h80000000, 32'h1, '0, 0, 1, 3'b111, 32'h80000000, 1, 1, 0, 1);
    // no flag updates: flags hold ov=1 neg=1 zero=0 although result is 0
    issue(4'd2, 32'h0, 32'h0, '0, 0, 0, 3'b000, 32'h0, 1, 1, 0, 1);
    // shifts, logic, immediate sign extension
    issue(4'd7, 32'hF0000000, 32'h0, 17'd4, 1, 0, 3'b111, 32'hFF000000, 0, 1, 0, 1);
    issue(4'd0, 32'h10, 32'h0, 17'h1FFFF, 1, 0, 3'b111, 32'h0000000F, 0, 0, 0, 1);
    issue(4'd2, 32'hF0F0F0F0, 32'hFF00FF00, '0, 0, 0, 3'b111, 32'hF000F000, 0, 1, 0, 1);
    issue(4'd3, 32'h0F0F0000, 32'h000000FF, '0, 0, 0, 3'b111, 32'h0F0F00FF, 0, 0, 0, 1);
    issue(4'd4, 32'h0, 32'h0, '0, 0, 0, 3'b111, 32'hFFFFFFFF, 0, 1, 0, 1);
    issue(4'd5, 32'h1, 32'd31, '0, 0, 0, 3'b111, 32'h80000000, 0, 1, 0, 1);
    issue(4'd6, 32'h80000000, 32'h23, '0, 0, 0, 3'b111, 32'h10000000, 0, 0, 0, 1);
    issue(4'd7, 32'h7FFFFFF0, 32'd4, '0, 0, 0, 3'b111, 32'h07FFFFFF, 0, 0, 0, 1);
    issue(4'd12, 32'd5, 32'd6, '0, 0, 0, 3'b111, 32'h0, 0, 0, 1, 1);
    issue(4'd1, 32'h0, 32'h1, '0, 0, 0, 3'b111, 32'hFFFFFFFF, 0, 1, 0, 1);

    // multiply with latency / busy window
    issue(4'd8, 32'h10000, 32'h10000, '0, 0, 0, 3'b111, 32'h0, 1, 0, 1, 1);
    bad = 0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (!busy || out_valid) bad = 1;
    end
    check("mul_busy_window", {63'd0, bad}, 64'd0);
    @(negedge clk);
    check("mul_done_valid_busy", {62'd0, out_valid, busy}, {62'd0, 2'b10});
    sync();
    issue(4'd8, 32'd3, 32'd5, '0, 0, 0, 3'b111, 32'd15, 0, 0, 0, 1);
    issue(4'd8, 32'hFFFFFFFF, 32'd2, '0, 0, 0, 3'b111, 32'hFFFFFFFE, 1, 1, 0, 1);
    repeat (W + 4) sync();

    // downstream stall
    out_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd2, '0, 0, 0, 3'b111, 32'd3, 0, 0, 0, 1);
    fork
      issue(4'd1, 32'd9, 32'd4, '0, 0, 0, 3'b111, 32'd5, 0, 0, 0, 1);
      begin
        bad = 0;
        repeat (5) begin
          @(negedge clk);
          if (ALU_result !== 32'd3 || !out_valid || in_ready) bad = 1;
        end
        check("stall_hold", {63'd0, bad}, 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    repeat (3) sync();

    // reset in the middle of a multiply
    issue(4'd8, 32'd3, 32'd5, '0, 0, 0, 3'b111, 32'd15, 0, 0, 0, 0);
    repeat (5) sync();
    rst_n = 1'b0;
    #1;
    check("mid_mul_reset_outputs",
          {26'd0, ALU_result, out_valid, flag_ov, flag_neg, flag_zero, busy, in_ready}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    sync();
    issue(4'd0, 32'd2, 32'd2, '0, 0, 0, 3'b111, 32'd4, 0, 0, 0, 1);

    // drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
